// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: bus widths, decode bundle layout and one-hot op encodings for the execute stage
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 162;
    localparam int ES_TO_MS_BUS_WD = 117;
    localparam int STALL_BUS_WD    = 10;
    localparam int FORWARD_BUS_WD  = 33;
    localparam int DIV_ITERS       = 32;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam int ST_SB  = 0;
    localparam int ST_SH  = 1;
    localparam int ST_SW  = 2;
    localparam int ST_SWL = 3;
    localparam int ST_SWR = 4;

    typedef struct packed {
        logic        hl_from_rs;
        logic [6:0]  inst_load;
        logic [4:0]  inst_store;
        logic [11:0] alu_op;
        logic [1:0]  mul_op;
        logic [1:0]  div_op;
        logic        load_op;
        logic [4:0]  ld_extd_op;
        logic        src1_is_sa;
        logic        src1_is_pc;
        logic        src1_is_hi;
        logic        src1_is_lo;
        logic        src2_is_imm;
        logic        src2_is_uimm;
        logic        src2_is_8;
        logic        gr_we;
        logic        hi_we;
        logic        lo_we;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [31:0] pc;
    } ds_bus_t;

endpackage

// File: rtl/exe_stage_div_iter.sv
// div_iter: restoring radix-2 divider on operand magnitudes with sign fix-up on the way out
module div_iter
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [5:0]  cnt;
    logic [63:0] sr;
    logic [31:0] dvs, abs_dd, abs_dv;
    logic [32:0] diff;
    logic        q_neg, r_neg;

    assign abs_dd    = (is_signed && dividend[31]) ? -dividend : dividend;
    assign abs_dv    = (is_signed && divisor[31]) ? -divisor : divisor;
    assign diff      = sr[63:31] - {1'b0, dvs};
    assign quotient  = q_neg ? -sr[31:0] : sr[31:0];
    assign remainder = r_neg ? -sr[63:32] : sr[63:32];

    // load magnitudes on start, then shift-subtract once per cycle; done holds the result until the next start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= 6'd0;
            sr    <= 64'd0;
            dvs   <= 32'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            done  <= 1'b0;
            cnt   <= 6'd0;
            sr    <= {32'd0, abs_dd};
            dvs   <= abs_dv;
            q_neg <= is_signed && (dividend[31] ^ divisor[31]);
            r_neg <= is_signed && dividend[31];
        end else if (busy) begin
            sr  <= diff[32] ? {sr[62:0], 1'b0} : {diff[31:0], sr[30:0], 1'b1};
            cnt <= cnt + 6'd1;
            if (cnt == 6'(DIV_ITERS - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage -- ALU, HI/LO, multiply/divide, data SRAM request and hazard feedback
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [STALL_BUS_WD-1:0]    stall_es_bus,
    output logic [FORWARD_BUS_WD-1:0]  forward_es_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);
    ds_bus_t     ds;
    logic        es_valid, es_ready_go, handoff, is_div, is_mul, is_mem;
    logic        div_start, div_started, div_busy, div_done, es_we_1;
    logic [31:0] hi, lo, src1, src2, es_result, div_q, div_r;
    logic [63:0] prod;

    assign is_div         = |ds.div_op;
    assign is_mul         = |ds.mul_op;
    assign is_mem         = ds.load_op || |ds.inst_store;
    assign es_ready_go    = !is_div || (div_started && div_done);
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign handoff        = es_to_ms_valid && ms_allowin;
    assign div_start      = es_valid && is_div && !div_started && !div_busy;
    assign prod           = {{32{ds.mul_op[0] & ds.rs_value[31]}}, ds.rs_value}
                          * {{32{ds.mul_op[0] & ds.rt_value[31]}}, ds.rt_value};

    assign data_sram_en   = handoff && is_mem;
    assign data_sram_addr = {es_result[31:2], 2'b00};
    assign es_we_1        = es_valid && ds.gr_we;
    assign stall_es_bus   = {es_we_1, {4{es_we_1}}, ds.dest};
    assign forward_es_bus = {es_we_1 && !ds.load_op && es_ready_go, es_result};
    assign es_to_ms_bus   = {ds.load_op, ds.inst_load, ds.ld_extd_op, ds.gr_we, ds.dest,
                             es_result[1:0], ds.rt_value, es_result, ds.pc};

    div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .is_signed (ds.div_op[0]),
        .dividend  (ds.rs_value),
        .divisor   (ds.rt_value),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // pipeline valid bit and decode bundle capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
            ds       <= '0;
        end else begin
            if (es_allowin) es_valid <= ds_to_es_valid;
            if (ds_to_es_valid && es_allowin) ds <= ds_bus_t'(ds_to_es_bus);
        end
    end

    // remember that the current divide was launched so a finished result is not restarted before handoff
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) div_started <= 1'b0;
        else if (handoff) div_started <= 1'b0;
        else if (div_start) div_started <= 1'b1;
    end

    // HI/LO commit only when the instruction leaves for the memory stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (handoff) begin
            if (is_div) begin
                hi <= div_r;
                lo <= div_q;
            end else if (is_mul) begin
                hi <= prod[63:32];
                lo <= prod[31:0];
            end else if (ds.hl_from_rs) begin
                if (ds.hi_we) hi <= ds.rs_value;
                if (ds.lo_we) lo <= ds.rs_value;
            end
        end
    end

    // operand muxes and one-hot ALU
    always_comb begin
        src1 = ds.src1_is_sa ? {27'd0, ds.imm[10:6]} : ds.src1_is_pc ? ds.pc :
               ds.src1_is_hi ? hi : ds.src1_is_lo ? lo : ds.rs_value;
        src2 = ds.src2_is_imm ? {{16{ds.imm[15]}}, ds.imm} : ds.src2_is_uimm ? {16'd0, ds.imm} :
               ds.src2_is_8 ? 32'd8 : ds.rt_value;
        es_result = 32'd0;
        if (ds.alu_op[ALU_ADD])       es_result = src1 + src2;
        else if (ds.alu_op[ALU_SUB])  es_result = src1 - src2;
        else if (ds.alu_op[ALU_SLT])  es_result = {31'd0, $signed(src1) < $signed(src2)};
        else if (ds.alu_op[ALU_SLTU]) es_result = {31'd0, src1 < src2};
        else if (ds.alu_op[ALU_AND])  es_result = src1 & src2;
        else if (ds.alu_op[ALU_NOR])  es_result = ~(src1 | src2);
        else if (ds.alu_op[ALU_OR])   es_result = src1 | src2;
        else if (ds.alu_op[ALU_XOR])  es_result = src1 ^ src2;
        else if (ds.alu_op[ALU_SLL])  es_result = src2 << src1[4:0];
        else if (ds.alu_op[ALU_SRL])  es_result = src2 >> src1[4:0];
        else if (ds.alu_op[ALU_SRA])  es_result = $signed(src2) >>> src1[4:0];
        else if (ds.alu_op[ALU_LUI])  es_result = {ds.imm, 16'd0};
    end

    // store byte enables and lane-aligned write data from the low address bits
    always_comb begin
        data_sram_wen   = 4'b0000;
        data_sram_wdata = ds.rt_value;
        if (ds.inst_store[ST_SW]) begin
            data_sram_wen = 4'b1111;
        end else if (ds.inst_store[ST_SB]) begin
            data_sram_wen   = 4'b0001 << es_result[1:0];
            data_sram_wdata = {4{ds.rt_value[7:0]}};
        end else if (ds.inst_store[ST_SH]) begin
            data_sram_wen   = es_result[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{ds.rt_value[15:0]}};
        end else if (ds.inst_store[ST_SWL]) begin
            data_sram_wen   = es_result[1] ? (es_result[0] ? 4'b1111 : 4'b0111)
                                           : (es_result[0] ? 4'b0011 : 4'b0001);
            data_sram_wdata = ds.rt_value >> {~es_result[1:0], 3'b000};
        end else if (ds.inst_store[ST_SWR]) begin
            data_sram_wen   = 4'b1111 << es_result[1:0];
            data_sram_wdata = ds.rt_value << {es_result[1:0], 3'b000};
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized and directed checks of exe_stage against a behavioural instruction model
module tb_exe_stage;

    localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_AND = 4, A_NOR = 5;
    localparam int A_OR = 6, A_XOR = 7, A_SLL = 8, A_SRL = 9, A_SRA = 10, A_LUI = 11;
    localparam int S_SB = 0, S_SH = 1, S_SW = 2, S_SWL = 3, S_SWR = 4;

    typedef struct packed {
        logic        hl_from_rs;
        logic [6:0]  inst_load;
        logic [4:0]  inst_store;
        logic [11:0] alu_op;
        logic [1:0]  mul_op;
        logic [1:0]  div_op;
        logic        load_op;
        logic [4:0]  ld_extd_op;
        logic        src1_is_sa, src1_is_pc, src1_is_hi, src1_is_lo;
        logic        src2_is_imm, src2_is_uimm, src2_is_8;
        logic        gr_we, hi_we, lo_we;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs_value, rt_value, pc;
    } tb_bus_t;

    logic         clk = 1'b0;
    logic         resetn, ms_allowin, es_allowin, ds_to_es_valid, es_to_ms_valid, data_sram_en;
    logic [161:0] ds_to_es_bus;
    logic [116:0] es_to_ms_bus;
    logic [9:0]   stall_es_bus;
    logic [32:0]  forward_es_bus;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;

    int           n_checks = 0, n_fail = 0;
    logic [31:0]  m_hi = 32'd0, m_lo = 32'd0;
    logic [31:0]  last_res, last_addr, last_wd;
    logic [3:0]   last_wen;
    tb_bus_t      b;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .stall_es_bus    (stall_es_bus),
        .forward_es_bus  (forward_es_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input tb_bus_t x);
        logic [31:0] a, c;
        int          op, sc;
        op = -1;
        for (int i = 0; i < 12; i++) if (x.alu_op[i]) op = i;
        a = x.src1_is_sa ? 32'(x.imm[10:6]) : x.src1_is_pc ? x.pc :
            x.src1_is_hi ? m_hi : x.src1_is_lo ? m_lo : x.rs_value;
        c = x.src2_is_imm ? 32'(int'($signed(x.imm))) : x.src2_is_uimm ? 32'(x.imm) :
            x.src2_is_8 ? 32'd8 : x.rt_value;
        sc = int'(c);
        case (op)
            A_ADD:   return a + c;
            A_SUB:   return a - c;
            A_SLT:   return (int'(a) < sc) ? 32'd1 : 32'd0;
            A_SLTU:  return (a < c) ? 32'd1 : 32'd0;
            A_AND:   return a & c;
            A_NOR:   return ~(a | c);
            A_OR:    return a | c;
            A_XOR:   return a ^ c;
            A_SLL:   return c << (a % 32);
            A_SRL:   return c >> (a % 32);
            A_SRA:   return 32'(sc >>> (a % 32));
            A_LUI:   return {x.imm, 16'd0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_store(input tb_bus_t x, input logic [31:0] addr,
                               output logic [3:0] wen, output logic [31:0] wd);
        int a;
        a   = int'(addr % 4);
        wen = 4'd0;
        wd  = x.rt_value;
        if (x.inst_store[S_SB]) begin wen = 4'(1 << a); wd = {4{x.rt_value[7:0]}}; end
        if (x.inst_store[S_SH]) begin wen = (a >= 2) ? 4'hC : 4'h3; wd = {2{x.rt_value[15:0]}}; end
        if (x.inst_store[S_SW]) wen = 4'hF;
        if (x.inst_store[S_SWL]) begin wen = 4'((1 << (a + 1)) - 1); wd = x.rt_value >> (8 * (3 - a)); end
        if (x.inst_store[S_SWR]) begin wen = 4'((15 << a) & 15); wd = x.rt_value << (8 * a); end
    endtask

    task automatic update_model(input tb_bus_t x);
        longint p;
        int     sd, sv;
        if (x.div_op != 0) begin
            if (x.rt_value == 0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = x.rs_value;
            end else if (x.div_op[0]) begin
                sd = int'(x.rs_value);
                sv = int'(x.rt_value);
                m_lo = 32'(sd / sv);
                m_hi = 32'(sd % sv);
            end else begin
                m_lo = x.rs_value / x.rt_value;
                m_hi = x.rs_value % x.rt_value;
            end
        end else if (x.mul_op != 0) begin
            if (x.mul_op[0]) p = longint'($signed(x.rs_value)) * longint'($signed(x.rt_value));
            else p = longint'({32'd0, x.rs_value}) * longint'({32'd0, x.rt_value});
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (x.hl_from_rs) begin
            if (x.hi_we) m_hi = x.rs_value;
            if (x.lo_we) m_lo = x.rs_value;
        end
    endtask

    // issue one instruction, hold ms_allowin low for 'stall' cycles once it is ready, check until handoff
    task automatic run(input tb_bus_t x, input int stall);
        int           rdy;
        bit           fin;
        logic         mem;
        logic [116:0] held;
        logic [31:0]  exp_res, exp_wd;
        logic [3:0]   exp_wen;
        rdy     = (x.div_op != 0) ? 33 : 0;
        mem     = x.load_op || (x.inst_store != 0);
        exp_res = model_alu(x);
        fin     = 0;
        held    = '0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = x;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = ~x;
        for (int k = 0; k < 80 && !fin; k++) begin
            ms_allowin = (k < rdy) ? 1'($urandom_range(0, 1)) : (k >= rdy + stall);
            #1;
            check("es_to_ms_valid", es_to_ms_valid, k >= rdy);
            check("es_allowin", es_allowin, (k >= rdy) && ms_allowin);
            check("sram_en", data_sram_en, (k >= rdy) && ms_allowin && mem);
            check("fwd_valid", forward_es_bus[32], x.gr_we && !x.load_op && (k >= rdy));
            check("stall_bus", stall_es_bus, {{5{x.gr_we}}, x.dest});
            if (k == rdy) held = es_to_ms_bus;
            else if (k > rdy) check("bus_stable", es_to_ms_bus, held);
            if (k >= rdy && ms_allowin) begin
                fin = 1;
                if (x.alu_op != 0) begin
                    check("es_result", es_to_ms_bus[63:32], exp_res);
                    check("fwd_data", forward_es_bus[31:0], exp_res);
                    check("addr_lo", es_to_ms_bus[97:96], exp_res[1:0]);
                end
                check("pc", es_to_ms_bus[31:0], x.pc);
                check("rt", es_to_ms_bus[95:64], x.rt_value);
                check("ctl", es_to_ms_bus[116:98], {x.load_op, x.inst_load, x.ld_extd_op, x.gr_we, x.dest});
                if (mem) begin
                    model_store(x, exp_res, exp_wen, exp_wd);
                    check("sram_addr", data_sram_addr, {exp_res[31:2], 2'b00});
                    check("sram_wen", data_sram_wen, exp_wen);
                    if (x.inst_store != 0) check("sram_wdata", data_sram_wdata, exp_wd);
                end
                last_res  = es_to_ms_bus[63:32];
                last_addr = data_sram_addr;
                last_wen  = data_sram_wen;
                last_wd   = data_sram_wdata;
                update_model(x);
            end
            @(posedge clk); #1;
        end
        if (!fin) check("handoff_timeout", 1'b0, 1'b1);
        ms_allowin = 1'b1;
    endtask

    function automatic tb_bus_t base();
        tb_bus_t x;
        x      = '0;
        x.pc   = $urandom;
        x.dest = 5'($urandom);
        return x;
    endfunction

    function automatic tb_bus_t mk_mf(input bit from_hi);
        tb_bus_t x;
        x = base();
        x.alu_op[A_ADD] = 1'b1;
        x.src1_is_hi    = from_hi;
        x.src1_is_lo    = !from_hi;
        x.gr_we         = 1'b1;
        return x;
    endfunction

    function automatic tb_bus_t mk_store(input int kind, input logic [31:0] addr, input logic [31:0] rt);
        tb_bus_t x;
        x = base();
        x.alu_op[A_ADD]   = 1'b1;
        x.src2_is_imm     = 1'b1;
        x.rs_value        = addr;
        x.rt_value        = rt;
        x.inst_store      = 5'(1 << kind);
        return x;
    endfunction

    function automatic tb_bus_t rand_inst();
        tb_bus_t x;
        x          = base();
        x.rs_value = $urandom;
        x.rt_value = $urandom;
        x.imm      = 16'($urandom);
        case ($urandom_range(0, 8))
            0, 1: begin
                x.alu_op = 12'(1 << $urandom_range(0, 11));
                x.gr_we  = 1'b1;
                case ($urandom_range(0, 3))
                    1: x.src2_is_imm  = 1'b1;
                    2: x.src2_is_uimm = 1'b1;
                    3: x.src1_is_sa   = 1'b1;
                    default: ;
                endcase
            end
            2: begin
                x.mul_op = 2'($urandom_range(1, 2));
                x.hi_we  = 1'b1;
                x.lo_we  = 1'b1;
            end
            3: begin
                x.div_op = 2'($urandom_range(1, 2));
                if ($urandom_range(0, 1)) x.rt_value = x.rt_value >> $urandom_range(8, 30);
                if (x.rt_value == 0) x.rt_value = 32'd1;
                if (x.rs_value == 32'h8000_0000 && x.rt_value == 32'hFFFF_FFFF) x.rt_value = 32'd1;
            end
            4: begin
                x.hl_from_rs = 1'b1;
                x.hi_we      = $urandom_range(0, 1);
                x.lo_we      = !x.hi_we;
            end
            5: x = mk_mf($urandom_range(0, 1));
            6: begin
                x.alu_op[A_ADD] = 1'b1;
                x.src2_is_imm   = 1'b1;
                x.load_op       = 1'b1;
                x.gr_we         = 1'b1;
                x.inst_load     = 7'(1 << $urandom_range(0, 6));
                x.ld_extd_op    = 5'($urandom);
            end
            7: begin
                x.alu_op[A_ADD] = 1'b1;
                x.src2_is_imm   = 1'b1;
                x.inst_store    = 5'(1 << $urandom_range(0, 4));
            end
            default: begin
                x.alu_op[A_ADD] = 1'b1;
                x.src1_is_pc    = 1'b1;
                x.src2_is_8     = 1'b1;
                x.gr_we         = 1'b1;
            end
        endcase
        return x;
    endfunction

    initial begin
        resetn         = 1'b0;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        #2;
        check("rst_es_to_ms_valid", es_to_ms_valid, 1'b0);
        check("rst_es_allowin", es_allowin, 1'b1);
        check("rst_sram_en", data_sram_en, 1'b0);
        check("rst_es_we", stall_es_bus[9:5], 5'd0);
        check("rst_fwd_valid", forward_es_bus[32], 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run(mk_mf(1'b1), 0);
        check("mfhi_after_reset", last_res, 32'd0);

        b = base();
        b.alu_op[A_ADD] = 1'b1;
        b.src2_is_imm   = 1'b1;
        b.gr_we         = 1'b1;
        b.rs_value      = 32'd5;
        b.imm           = 16'hFFFF;
        run(b, 0);
        check("addiu_result", last_res, 32'd4);

        b = base();
        b.mul_op   = 2'b01;
        b.hi_we    = 1'b1;
        b.lo_we    = 1'b1;
        b.rs_value = 32'hFFFF_FFFD;
        b.rt_value = 32'd5;
        run(b, 0);
        run(mk_mf(1'b0), 0);
        check("mult_lo", last_res, 32'hFFFF_FFF1);
        run(mk_mf(1'b1), 0);
        check("mult_hi", last_res, 32'hFFFF_FFFF);

        b = base();
        b.div_op   = 2'b01;
        b.rs_value = 32'hFFFF_FFF9;
        b.rt_value = 32'd2;
        run(b, 3);
        run(mk_mf(1'b0), 0);
        check("div_lo", last_res, 32'hFFFF_FFFD);
        run(mk_mf(1'b1), 0);
        check("div_hi", last_res, 32'hFFFF_FFFF);

        run(mk_store(S_SB, 32'h1003, 32'h1122_3344), 0);
        check("sb_addr", last_addr, 32'h1000);
        check("sb_wen", last_wen, 4'b1000);
        check("sb_wdata", last_wd, 32'h4444_4444);
        run(mk_store(S_SWL, 32'h1001, 32'h1122_3344), 0);
        check("swl_wen", last_wen, 4'b0011);
        check("swl_wdata", last_wd, 32'h0000_1122);
        run(mk_store(S_SWR, 32'h1002, 32'h1122_3344), 0);
        check("swr_wen", last_wen, 4'b1100);
        check("swr_wdata", last_wd, 32'h3344_0000);

        b = base();
        b.alu_op[A_ADD] = 1'b1;
        b.src2_is_imm   = 1'b1;
        b.load_op       = 1'b1;
        b.gr_we         = 1'b1;
        b.inst_load     = 7'b0000001;
        b.rs_value      = 32'h2000;
        b.imm           = 16'h0010;
        run(b, 3);

        b = base();
        b.div_op   = 2'b01;
        b.rs_value = 32'd1000;
        b.rt_value = 32'd3;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("div_c10_not_ready", es_to_ms_valid, 1'b0);
        resetn = 1'b0;
        #1;
        check("midrst_es_to_ms_valid", es_to_ms_valid, 1'b0);
        check("midrst_es_allowin", es_allowin, 1'b1);
        check("midrst_es_we", stall_es_bus[9:5], 5'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk); #1;
        resetn = 1'b1;
        run(mk_mf(1'b1), 0);
        check("midrst_hi", last_res, 32'd0);
        run(mk_mf(1'b0), 0);
        check("midrst_lo", last_res, 32'd0);

        b = base();
        b.div_op   = 2'b10;
        b.rs_value = 32'd100;
        b.rt_value = 32'd7;
        run(b, 0);
        run(mk_mf(1'b0), 0);
        check("divu_lo", last_res, 32'd14);
        run(mk_mf(1'b1), 0);
        check("divu_hi", last_res, 32'd2);

        b = base();
        b.div_op   = 2'b10;
        b.rs_value = 32'h1234_5678;
        b.rt_value = 32'd0;
        run(b, 1);
        run(mk_mf(1'b0), 0);
        check("div0_lo", last_res, 32'hFFFF_FFFF);
        run(mk_mf(1'b1), 0);
        check("div0_hi", last_res, 32'h1234_5678);

        for (int n = 0; n < 80; n++) run(rand_inst(), $urandom_range(0, 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the decode stage and upstream of the memory stage.
- Consumes the decoded bundle, computes the ALU result and owns the HI/LO registers.
- Runs single-cycle multiply and a multi-cycle iterative divide.
- Issues the data-SRAM request for loads and stores, and feeds the stall/forward information back to decode.

Parameters:
- DIV_ITERS, 32, number of radix-2 divider iteration cycles. Fixed; not overridable per instance.

Ports:
- clk  in  1  single clock
- resetn  in  1  asynchronous, active-low reset
- ms_allowin  in  1  memory stage can accept
- es_allowin  out  1  this stage can accept
- ds_to_es_valid  in  1  decode bundle valid
- ds_to_es_bus  in  `DS_TO_ES_BUS_WD (162)  fields, MSB first: hl_from_rs 161, inst_load 160:154, inst_store 153:149, alu_op 148:137, mul_op 136:135, div_op 134:133, load_op 132, ld_extd_op 131:127, src1_is_sa 126, src1_is_pc 125, src1_is_hi 124, src1_is_lo 123, src2_is_imm 122, src2_is_uimm 121, src2_is_8 120, gr_we 119, hi_we 118, lo_we 117, dest 116:112, imm 111:96, rs_value 95:64, rt_value 63:32, pc 31:0
- es_to_ms_valid  out  1
- es_to_ms_bus  out  `ES_TO_MS_BUS_WD (117)  fields: load_op 116, inst_load 115:109, ld_extd_op 108:104, gr_we 103, dest 102:98, addr_lo 97:96, rt_value 95:64, es_result 63:32, pc 31:0
- stall_es_bus  out  `STALL_BUS_WD (10)  {es_we_1, es_we[3:0], es_dest}
- forward_es_bus  out  `FORWARD_BUS_WD (33)  {es_forward_valid, es_forward_data}
- data_sram_en  out  1
- data_sram_wen  out  4
- data_sram_addr  out  32
- data_sram_wdata  out  32

Behaviour:
- Reset (resetn low, asynchronous):
  - es_valid=0, HI=0, LO=0, divider idle.
  - Outputs: es_to_ms_valid=0, es_allowin=1, data_sram_en=0, es_we_1=0, es_we=0, es_forward_valid=0.
  - Reset mid-divide aborts the divide with no HI/LO write.
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_to_ms_valid = es_valid && es_ready_go.
  - When es_allowin: es_valid <= ds_to_es_valid. The bundle register loads only when ds_to_es_valid && es_allowin.
  - Handoff = es_to_ms_valid && ms_allowin.
- Operands:
  - src1 priority: sa ({27'b0, imm[10:6]}) > pc > HI > LO > rs_value.
  - src2 priority: sign-extended imm > zero-extended imm > 32'd8 > rt_value.
- ALU (12 one-hot ops):
  - add (no overflow trap), sub, slt (signed), sltu, and, nor, or, xor.
  - sll/srl/sra: shift src2 by src1[4:0].
  - lui: {imm, 16'b0}.
  - es_result = ALU output.
- Multiply:
  - mul_op[0] signed, mul_op[1] unsigned. 64-bit product is combinational.
  - ready_go=1. On handoff: HI <= prod[63:32], LO <= prod[31:0].
- Divide (sub-module):
  - Starts when an instruction with |div_op enters EXE; the entry cycle is cycle 0.
  - Performs DIV_ITERS restoring iterations on |rs|/|rt|. ready_go=0 in cycles 0..32 and 1 from cycle 33.
  - The result is held stable while ms_allowin is low. A done flag prevents restart until handoff.
  - Signed divide: quotient negated when operand signs differ; remainder takes the dividend's sign.
  - Divide by zero does not trap. The result is whatever the algorithm yields (quotient 0xFFFFFFFF before sign fix, remainder |rs|).
  - On handoff: LO <= quotient, HI <= remainder.
- mthi/mtlo: on handoff, HI or LO <= rs_value (selected by hl_from_rs with hi_we/lo_we).
  - mfhi/mflo read the current HI/LO, which already includes any write from the prior instruction.
- Non-EXE instructions: ready_go=1.
- Data SRAM:
  - data_sram_en = es_valid && es_ready_go && ms_allowin && (load_op | |inst_store).
  - data_sram_addr = {es_result[31:2], 2'b00}; addr_lo = es_result[1:0].
  - sw: wen=1111, wdata=rt.
  - sb: wen=0001<<addr_lo, wdata={4{rt[7:0]}}.
  - sh: wen = addr_lo[1] ? 1100 : 0011, wdata={2{rt[15:0]}}.
  - swl, addr_lo 0/1/2/3: wen 0001/0011/0111/1111, wdata rt>>24 / >>16 / >>8 / >>0.
  - swr, addr_lo 0/1/2/3: wen 1111/1110/1100/1000, wdata rt<<0 / <<8 / <<16 / <<24.
  - Loads: wen=0000.
- Hazard outputs:
  - es_we_1 = es_valid && gr_we; es_we = {4{es_we_1}}; es_dest = dest.
  - es_forward_valid = es_we_1 && !load_op && es_ready_go; es_forward_data = es_result.

Decomposition:
- Shared constants go in mycpu.h: DS_TO_ES_BUS_WD, ES_TO_MS_BUS_WD=117, STALL_BUS_WD=10, FORWARD_BUS_WD=33.
- One sub-module, div_iter:
  - Inputs: clk, resetn, start, signed, dividend, divisor.
  - Outputs: busy, done, quotient, remainder.
  - Internal: 6-bit counter and 64-bit shift register.

Test Plan:
- addiu with rs=5, imm=0xFFFF, ms_allowin=1 -> es_result=4, es_forward_valid=1, es_we=1111; es_to_ms_valid in the same cycle.
- mult with rs=-3, rt=5, then mflo -> after handoff HI=0xFFFFFFFF, LO=0xFFFFFFF1; the mflo es_result=0xFFFFFFF1.
- div with rs=-7, rt=2, ms_allowin held low cycles 33-35 -> ready_go first 1 at cycle 33; es_allowin=0 until handoff at cycle 36; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Stores with rt=0x11223344:
  - sb at 0x1003 -> addr 0x1000, wen 1000, wdata 0x44444444.
  - swl at 0x1001 -> wen 0011, wdata 0x00001122.
  - swr at 0x1002 -> wen 1100, wdata 0x33440000.
- lw followed by ms_allowin low for 3 cycles -> data_sram_en=0 and es_to_ms_bus stable during the stall; en=1 for exactly 1 cycle at handoff; es_forward_valid=0 throughout.
- resetn pulsed low at divide cycle 10 -> es_valid=0, HI=LO=0 immediately. A following divu 100/7 completes at cycle 33 with LO=14, HI=2.
